dmem_ctrl: RTL and testbench

Parametrised, clocked data memory for the pipeline's MEM stage. Byte-addressed, little-endian, with a valid/ready request channel, a valid/ready response channel and a configurable read latency. Byte, half and word accesses are supported, with sign or zero extension on loads and an error response for illegal accesses. It replaces the combinational data memory so that the pipeline can tolerate multi-cycle memory.

---
 rtl/dmem_ctrl.sv | 130 +++++++++++++
 tb/tb_dmem_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Byte-addressed little-endian data memory with valid/ready request and response channels.
// Define DMEM_ALIGN_CHECK_EN to turn misaligned half/word accesses into error responses.
module dmem_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
    parameter int          DEPTH_BYTES = 1048576,
    parameter int          LATENCY     = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int AW = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic        live;
    logic [31:0] cnt;
    logic [31:0] rdata_q;
    logic        error_q;

    logic [7:0]    mem [DEPTH_BYTES];
    logic [31:0]   off;
    logic [2:0]    nbytes;
    logic [33:0]   last;
    logic          size_err;
    logic          range_err;
    logic          align_err;
    logic          req_err;
    logic          accept;
    logic [AW-1:0] idx [4];
    logic [31:0]   load_val;

    // Request decode: offset, byte count, legality and byte indices
    always_comb begin
        off      = req_addr - BASE_ADDR;
        nbytes   = 3'd4;
        case (req_size)
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        last      = {2'b00, off} + {31'b0, nbytes} - 34'd1;
        size_err  = (req_size == 2'd3);
        range_err = (last >= 34'(DEPTH_BYTES));
`ifdef DMEM_ALIGN_CHECK_EN
        align_err = ((req_size == 2'd1) && req_addr[0]) ||
                    ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
`else
        align_err = 1'b0;
`endif
        req_err = size_err || range_err || align_err;
        for (int k = 0; k < 4; k++) begin
            idx[k] = off[AW-1:0] + AW'(k);
        end
    end

    // Little-endian load assembly with sign or zero extension
    always_comb begin
        load_val = 32'h0;
        case (req_size)
            2'd0:    load_val = {{24{~req_unsigned & mem[idx[0]][7]}}, mem[idx[0]]};
            2'd1:    load_val = {{16{~req_unsigned & mem[idx[1]][7]}}, mem[idx[1]], mem[idx[0]]};
            default: load_val = {mem[idx[3]], mem[idx[2]], mem[idx[1]], mem[idx[0]]};
        endcase
    end

    assign req_ready = live && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_error = error_q;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (LATENCY > 1) ? WAIT : RESP;
            WAIT: if (cnt <= 32'd1) state_next = RESP;
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            live    <= 1'b0;
            cnt     <= 32'd0;
            rdata_q <= 32'd0;
            error_q <= 1'b0;
        end else begin
            state <= state_next;
            live  <= 1'b1;
            if (accept) begin
                cnt     <= 32'(LATENCY - 1);
                error_q <= req_err;
                rdata_q <= (req_write || req_err) ? 32'd0 : load_val;
            end else if (state == WAIT) begin
                cnt <= cnt - 32'd1;
            end
        end
    end

    // Array is deliberately never reset; stores commit on the accept edge
    always_ff @(posedge clock) begin
        if (accept && req_write && !req_err) begin
            mem[idx[0]] <= req_wdata[7:0];
            if (nbytes >= 3'd2) begin
                mem[idx[1]] <= req_wdata[15:8];
            end
            if (nbytes == 3'd4) begin
                mem[idx[2]] <= req_wdata[23:16];
                mem[idx[3]] <= req_wdata[31:24];
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed testbench for dmem_ctrl: three instances with LATENCY 1, 3 and 4.
module tb_dmem_ctrl;

    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;

    logic        req_valid_1 = 1'b0, req_valid_3 = 1'b0, req_valid_4 = 1'b0;
    logic        rsp_ready_1 = 1'b0, rsp_ready_3 = 1'b0, rsp_ready_4 = 1'b0;
    logic        req_ready_1, req_ready_3, req_ready_4;
    logic        rsp_valid_1, rsp_valid_3, rsp_valid_4;
    logic        rsp_error_1, rsp_error_3, rsp_error_4;
    logic [31:0] rsp_rdata_1, rsp_rdata_3, rsp_rdata_4;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    dmem_ctrl #(.BASE_ADDR(BASE), .DEPTH_BYTES(1048576), .LATENCY(1)) u1 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid_1), .req_ready(req_ready_1), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1),
        .rsp_rdata(rsp_rdata_1), .rsp_error(rsp_error_1)
    );

    dmem_ctrl #(.BASE_ADDR(BASE), .DEPTH_BYTES(1024), .LATENCY(3)) u3 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid_3), .req_ready(req_ready_3), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3),
        .rsp_rdata(rsp_rdata_3), .rsp_error(rsp_error_3)
    );

    dmem_ctrl #(.BASE_ADDR(BASE), .DEPTH_BYTES(1024), .LATENCY(4)) u4 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid_4), .req_ready(req_ready_4), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready_4),
        .rsp_rdata(rsp_rdata_4), .rsp_error(rsp_error_4)
    );

    function automatic logic get_ready(input int inst);
        case (inst)
            1:       return req_ready_1;
            3:       return req_ready_3;
            default: return req_ready_4;
        endcase
    endfunction

    function automatic logic get_valid(input int inst);
        case (inst)
            1:       return rsp_valid_1;
            3:       return rsp_valid_3;
            default: return rsp_valid_4;
        endcase
    endfunction

    function automatic logic [31:0] get_rdata(input int inst);
        case (inst)
            1:       return rsp_rdata_1;
            3:       return rsp_rdata_3;
            default: return rsp_rdata_4;
        endcase
    endfunction

    function automatic logic get_error(input int inst);
        case (inst)
            1:       return rsp_error_1;
            3:       return rsp_error_3;
            default: return rsp_error_4;
        endcase
    endfunction

    task automatic set_valid(input int inst, input logic v);
        case (inst)
            1:       req_valid_1 = v;
            3:       req_valid_3 = v;
            default: req_valid_4 = v;
        endcase
    endtask

    task automatic set_rsp_ready(input int inst, input logic v);
        case (inst)
            1:       rsp_ready_1 = v;
            3:       rsp_ready_3 = v;
            default: rsp_ready_4 = v;
        endcase
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction; hold keeps rsp_ready low for that many cycles after rsp_valid rises
    task automatic apply_stimulus(input int inst, input logic wr, input logic [31:0] addr,
                                  input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                                  input int hold, output logic [31:0] rdata, output logic err,
                                  output int lat);
        int waited;
        @(negedge clock);
        req_addr     = addr;
        req_write    = wr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        set_valid(inst, 1'b1);
        waited = 0;
        while (!get_ready(inst) && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (!get_ready(inst)) begin
            check_output("req_ready_timeout", 32'(get_ready(inst)), 32'd1);
            set_valid(inst, 1'b0);
            rdata = 'x;
            err   = 1'bx;
            lat   = -1;
            return;
        end
        @(posedge clock);
        @(negedge clock);
        set_valid(inst, 1'b0);
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h0BAD_0BAD;
        lat = 1;
        while (!get_valid(inst) && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        if (!get_valid(inst)) begin
            check_output("rsp_valid_timeout", 32'(get_valid(inst)), 32'd1);
            rdata = 'x;
            err   = 1'bx;
            return;
        end
        rdata = get_rdata(inst);
        err   = get_error(inst);
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            check_output("hold_rdata", get_rdata(inst), rdata);
            check_output("hold_valid", 32'(get_valid(inst)), 32'd1);
            check_output("hold_req_ready", 32'(get_ready(inst)), 32'd0);
        end
        set_rsp_ready(inst, 1'b1);
        @(negedge clock);
        set_rsp_ready(inst, 1'b0);
        check_output("post_hs_req_ready", 32'(get_ready(inst)), 32'd1);
        check_output("post_hs_rsp_valid", 32'(get_valid(inst)), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          seen;

        // Reset values
        repeat (3) @(negedge clock);
        check_output("rst_req_ready_1", 32'(req_ready_1), 32'd0);
        check_output("rst_rsp_valid_1", 32'(rsp_valid_1), 32'd0);
        check_output("rst_rsp_rdata_1", rsp_rdata_1, 32'd0);
        check_output("rst_rsp_error_1", 32'(rsp_error_1), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check_output("rel_req_ready_1", 32'(req_ready_1), 32'd1);

        // Reset mid-WAIT on the LATENCY=3 instance drops the response
        req_addr  = BASE;
        req_write = 1'b0;
        req_size  = 2'd2;
        req_valid_3 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid_3 = 1'b0;
        check_output("wait_rsp_valid_3", 32'(rsp_valid_3), 32'd0);
        reset = 1'b0;
        #1;
        check_output("midrst_req_ready_3", 32'(req_ready_3), 32'd0);
        check_output("midrst_rsp_valid_3", 32'(rsp_valid_3), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_output("midrst_rel_ready_3", 32'(req_ready_3), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (rsp_valid_3) seen = 1'b1;
        end
        check_output("dropped_rsp_3", 32'(seen), 32'd0);

        // Word round trip
        apply_stimulus(1, 1'b1, 32'h0100_0010, 2'd2, 1'b0, 32'hDEAD_BEEF, 0, rd, er, lat);
        check_output("sw_err", 32'(er), 32'd0);
        check_output("sw_rdata", rd, 32'd0);
        check_output("sw_lat", 32'(lat), 32'd1);
        apply_stimulus(1, 1'b0, 32'h0100_0010, 2'd2, 1'b0, 32'h0, 0, rd, er, lat);
        check_output("lw_rdata", rd, 32'hDEAD_BEEF);
        check_output("lw_err", 32'(er), 32'd0);
        check_output("lw_lat", 32'(lat), 32'd1);

        // Byte/half extension
        apply_stimulus(1, 1'b0, 32'h0100_0013, 2'd0, 1'b0, 32'h0, 0, rd, er, lat);
        check_output("lb_signed", rd, 32'hFFFF_FFDE);
        apply_stimulus(1, 1'b0, 32'h0100_0013, 2'd0, 1'b1, 32'h0, 0, rd, er, lat);
        check_output("lbu", rd, 32'h0000_00DE);
        apply_stimulus(1, 1'b0, 32'h0100_0010, 2'd1, 1'b0, 32'h0, 0, rd, er, lat);
        check_output("lh_signed", rd, 32'hFFFF_BEEF);
        apply_stimulus(1, 1'b1, 32'h0100_0011, 2'd0, 1'b0, 32'hAAAA_AA55, 0, rd, er, lat);
        apply_stimulus(1, 1'b0, 32'h0100_0010, 2'd2, 1'b0, 32'h0, 0, rd, er, lat);
        check_output("sb_merge", rd, 32'hDEAD_55EF);
        apply_stimulus(1, 1'b0, 32'h0100_0010, 2'd1, 1'b1, 32'h0, 0, rd, er, lat);
        check_output("lhu", rd, 32'h0000_55EF);

        // Range and size errors
        apply_stimulus(1, 1'b0, 32'h00FF_FFFC, 2'd2, 1'b0, 32'h0, 0, rd, er, lat);
        check_output("below_base_err", 32'(er), 32'd1);
        check_output("below_base_rdata", rd, 32'd0);
        apply_stimulus(1, 1'b1, 32'h010F_FFFE, 2'd1, 1'b0, 32'h0000_1234, 0, rd, er, lat);
        check_output("top_half_err", 32'(er), 32'd0);
        apply_stimulus(1, 1'b1, 32'h010F_FFFE, 2'd2, 1'b0, 32'hCAFE_F00D, 0, rd, er, lat);
        check_output("top_word_err", 32'(er), 32'd1);
        apply_stimulus(1, 1'b0, 32'h010F_FFFE, 2'd1, 1'b1, 32'h0, 0, rd, er, lat);
        check_output("top_unchanged", rd, 32'h0000_1234);
        apply_stimulus(1, 1'b1, 32'h0100_0010, 2'd3, 1'b0, 32'h1111_1111, 0, rd, er, lat);
        check_output("size3_err", 32'(er), 32'd1);
        check_output("size3_rdata", rd, 32'd0);
        apply_stimulus(1, 1'b0, 32'h0100_0010, 2'd2, 1'b0, 32'h0, 0, rd, er, lat);
        check_output("size3_no_write", rd, 32'hDEAD_55EF);

        // Alignment
`ifdef DMEM_ALIGN_CHECK_EN
        apply_stimulus(1, 1'b0, 32'h0100_0011, 2'd1, 1'b0, 32'h0, 0, rd, er, lat);
        check_output("misaligned_half_err", 32'(er), 32'd1);
`else
        apply_stimulus(1, 1'b1, 32'h0100_0021, 2'd2, 1'b0, 32'h1122_3344, 0, rd, er, lat);
        check_output("unaligned_sw_err", 32'(er), 32'd0);
        apply_stimulus(1, 1'b0, 32'h0100_0021, 2'd0, 1'b1, 32'h0, 0, rd, er, lat);
        check_output("ua_byte21", rd, 32'h44);
        apply_stimulus(1, 1'b0, 32'h0100_0022, 2'd0, 1'b1, 32'h0, 0, rd, er, lat);
        check_output("ua_byte22", rd, 32'h33);
        apply_stimulus(1, 1'b0, 32'h0100_0023, 2'd0, 1'b1, 32'h0, 0, rd, er, lat);
        check_output("ua_byte23", rd, 32'h22);
        apply_stimulus(1, 1'b0, 32'h0100_0024, 2'd0, 1'b1, 32'h0, 0, rd, er, lat);
        check_output("ua_byte24", rd, 32'h11);
`endif

        // Backpressure and latency on the LATENCY=4 instance
        apply_stimulus(4, 1'b1, BASE, 2'd2, 1'b0, 32'h8000_0001, 0, rd, er, lat);
        check_output("l4_sw_lat", 32'(lat), 32'd4);
        apply_stimulus(4, 1'b0, BASE, 2'd2, 1'b0, 32'h0, 5, rd, er, lat);
        check_output("l4_lw_lat", 32'(lat), 32'd4);
        check_output("l4_lw_rdata", rd, 32'h8000_0001);
        apply_stimulus(4, 1'b0, BASE + 32'd2, 2'd1, 1'b0, 32'h0, 0, rd, er, lat);
        check_output("l4_lh_signed", rd, 32'hFFFF_8000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
